row_accum_ctrl: RTL and testbench

- Sequencing controller for GNN neighbour aggregation.
- Accepts a per-node degree, then consumes that many feature rows of NUM_ELEM unsigned elements over a valid/ready stream.
- Sums the rows element-wise into an accumulator register and emits one aggregated row per node.
- Sits between the neighbour-feature fetch stage and the combination (weight-multiply) stage.

---
 rtl/row_accum_pkg.sv | 15 +
 rtl/row_accum_ctrl_if.sv | 26 ++
 rtl/row_accum_reg.sv | 47 ++++
 rtl/row_accum_ctrl.sv | 74 +++++++
 tb/tb_row_accum_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/row_accum_pkg.sv
// Shared widths, row types and controller states for the row accumulator slice.
// Single-cycle row add; no storage of its own, so no back-pressure concerns.
package row_accum_pkg;

   localparam int ELEM_W   = 16;
   localparam int NUM_ELEM = 3;
   localparam int DEG_W    = 8;

   typedef logic [ELEM_W-1:0]   elem_t;
   typedef elem_t [NUM_ELEM-1:0] row_t;
   typedef logic [DEG_W-1:0]    deg_t;

   typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

endpackage

// File: rtl/row_accum_ctrl_if.sv
// Control and row-stream bundle between the fetch stage, the accumulator and the combine stage.
// Pure wiring: valid/ready on both streams, start/deg pulse for node setup.
interface row_accum_ctrl_if;
   import row_accum_pkg::*;

   logic start;
   deg_t deg;
   logic busy;
   logic in_valid;
   logic in_ready;
   row_t in_row;
   logic out_valid;
   logic out_ready;
   row_t out_row;

   modport master (
      output start, deg, in_valid, in_row, out_ready,
      input  busy, in_ready, out_valid, out_row
   );

   modport slave (
      input  start, deg, in_valid, in_row, out_ready,
      output busy, in_ready, out_valid, out_row
   );

endinterface

// File: rtl/row_accum_reg.sv
// Accumulator bank with element-wise adders; sum lands one cycle after add_en.
// Saturating adds when ROW_ACCUM_SAT_EN is defined, modulo wrap otherwise; no back-pressure.
module row_accum_reg
   import row_accum_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic add_en,
   input  row_t row,
   output row_t acc
);

   row_t sum;

`ifdef ROW_ACCUM_SAT_EN
   logic [NUM_ELEM-1:0][ELEM_W:0] wide;

   // Clamping on carry-out also keeps an already saturated element pinned at all ones.
   always_comb begin
      wide = '0;
      sum  = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         wide[i] = {1'b0, acc[i]} + {1'b0, row[i]};
         sum[i]  = wide[i][ELEM_W] ? '1 : wide[i][ELEM_W-1:0];
      end
   end
`else
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         sum[i] = acc[i] + row[i];
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/row_accum_ctrl.sv
// Per-node neighbour aggregation: sums deg rows and emits one row; out_valid the cycle after the last input (ROW_ACCUM_SAT_EN selects saturation).
// in_valid low stalls accumulation, out_ready low holds the result; nothing is dropped.
module row_accum_ctrl
   import row_accum_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   row_accum_ctrl_if.slave   bus
);

   state_t state_q, state_d;
   deg_t   rem_q, rem_d;
   logic   clr;
   logic   add_en;
   row_t   acc;

   row_accum_reg u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .add_en (add_en),
      .row    (bus.in_row),
      .acc    (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      clr     = 1'b0;
      add_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               clr     = 1'b1;
               rem_d   = bus.deg;
               // A zero-degree node skips straight to emitting the cleared row.
               state_d = (bus.deg == '0) ? EMIT : ACCUM;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               add_en = 1'b1;
               rem_d  = rem_q - deg_t'(1);
               if (rem_q == deg_t'(1)) begin
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from registers, so out_row stays stable while EMIT is held.
   assign bus.busy      = (state_q != IDLE);
   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_row   = acc;

endmodule

// File: tb/tb_row_accum_ctrl.sv
// Directed bench for row_accum_ctrl: arithmetic reference model plus cycle-level output checker.
module tb_row_accum_ctrl;
   import row_accum_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   row_accum_ctrl_if bus();

   row_accum_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   errors = 0;
   int   checks = 0;
   row_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic row_t mk(input int a, input int b, input int c);
      row_t r;
      r[0] = elem_t'(a);
      r[1] = elem_t'(b);
      r[2] = elem_t'(c);
      return r;
   endfunction

   // Reference: integer sum of every row, then wrap or clamp once (equivalent for unsigned inputs).
   function automatic row_t model_sum(input row_t rows[$]);
      row_t   r;
      longint s;
      longint lim;
      lim = longint'(1) << ELEM_W;
      r = '0;
      for (int e = 0; e < NUM_ELEM; e++) begin
         s = 0;
         foreach (rows[k]) s += longint'(rows[k][e]);
`ifdef ROW_ACCUM_SAT_EN
         if (s > lim - 1) s = lim - 1;
`else
         s = s % lim;
`endif
         r[e] = elem_t'(s);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle checker: result matches model, held stable under back-pressure, streams exclusive.
   logic prev_hold = 1'b0;
   row_t prev_row  = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_row", 64'(bus.out_row), 64'(prev_row));
         end
         if (bus.out_valid) begin
            check("excl_in_ready", 64'(bus.in_ready), 64'(0));
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got row %0h, expected no output", bus.out_row);
            end else begin
               check("model_row", 64'(bus.out_row), 64'(exp_q[0]));
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_row  = bus.out_row;
      end
   end

   task automatic do_node(input string tag, input int d, input row_t rows[$], input row_t lit, input int stall);
      exp_q.push_back(model_sum(rows));
      check({tag, "_model"}, 64'(model_sum(rows)), 64'(lit));
      bus.start = 1'b1;
      bus.deg   = deg_t'(d);
      tick();
      bus.start = 1'b0;
      bus.deg   = 8'hA5;
      foreach (rows[k]) begin
         bus.in_valid = 1'b1;
         bus.in_row   = rows[k];
         @(negedge clk);
         check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
         check({tag, "_early_valid"}, 64'(bus.out_valid), 64'(0));
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_row   = mk(16'h1234, 16'h4321, 16'hBEEF);
      @(negedge clk);
      check({tag, "_valid_rise"}, 64'(bus.out_valid), 64'(1));
      check({tag, "_no_in_ready"}, 64'(bus.in_ready), 64'(0));
      check({tag, "_row"}, 64'(bus.out_row), 64'(lit));
      repeat (stall) tick();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'(0));
      check({tag, "_idle"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      row_t rows[$];
      bus.start     = 1'b0;
      bus.deg       = '0;
      bus.in_valid  = 1'b0;
      bus.in_row    = '0;
      bus.out_ready = 1'b0;

      #1;
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_row", 64'(bus.out_row), 64'(0));
      #12 rst_n = 1'b1;
      tick();

      rows = {mk(1, 2, 3), mk(10, 20, 30), mk(100, 200, 300)};
      do_node("t1", 3, rows, mk(111, 222, 333), 0);

      rows = {};
      do_node("t2", 0, rows, mk(0, 0, 0), 2);

      rows = {mk(16'hFFFF, 1, 16'h8000), mk(2, 1, 16'h8000)};
`ifdef ROW_ACCUM_SAT_EN
      do_node("t3", 2, rows, mk(16'hFFFF, 2, 16'hFFFF), 0);
`else
      do_node("t3", 2, rows, mk(16'h0001, 2, 16'h0000), 0);
`endif

      // Gapped input, 5-cycle output stall, and a start held across EMIT.
      rows = {mk(1, 2, 3), mk(4, 5, 6)};
      exp_q.push_back(model_sum(rows));
      check("t4_model", 64'(model_sum(rows)), 64'(mk(5, 7, 9)));
      bus.start = 1'b1;
      bus.deg   = 8'd2;
      tick();
      bus.start    = 1'b0;
      bus.deg      = 8'd7;
      bus.in_valid = 1'b1;
      bus.in_row   = rows[0];
      tick();
      bus.in_valid = 1'b0;
      bus.in_row   = mk(99, 99, 99);
      tick();
      tick();
      bus.in_valid = 1'b1;
      bus.in_row   = rows[1];
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("t4_valid_rise", 64'(bus.out_valid), 64'(1));
      bus.start = 1'b1;
      bus.deg   = 8'd1;
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         check("t4_stall_valid", 64'(bus.out_valid), 64'(1));
         check("t4_stall_row", 64'(bus.out_row), 64'(mk(5, 7, 9)));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
      check("t4_start_ignored", 64'(bus.busy), 64'(0));
      check("t4_valid_drop", 64'(bus.out_valid), 64'(0));
      tick();
      @(negedge clk);
      check("t4_still_idle", 64'(bus.busy), 64'(0));

      // Reset mid-node: partial sum must vanish without producing an output.
      bus.start = 1'b1;
      bus.deg   = 8'd4;
      tick();
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_row   = mk(1, 1, 1);
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy", 64'(bus.busy), 64'(0));
      check("t5_rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("t5_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("t5_rst_out_row", 64'(bus.out_row), 64'(0));
      bus.in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("t5_idle_after_rst", 64'(bus.busy), 64'(0));
      rows = {mk(7, 8, 9)};
      do_node("t5", 1, rows, mk(7, 8, 9), 1);

      rows = {mk(5, 5, 5)};
      do_node("t6a", 1, rows, mk(5, 5, 5), 0);
      rows = {mk(6, 6, 6)};
      do_node("t6b", 1, rows, mk(6, 6, 6), 0);

      tick();
      check("drain", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
